// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - opcode map, register indices and helpers shared by the Fibonacci datapath
package fibo_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDK  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_LDIN = 3'b100;
    localparam logic [2:0] OP_WB   = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    // True for opcodes that load ACC and the Z register from the ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_DEC) || (op == OP_ADD) || (op == OP_PASS);
    endfunction

endpackage

// File: rtl/fibo_alu.sv
// rtl/fibo_alu.sv - combinational ALU (SUB/DEC/ADD/PASS) with zero detect
module fibo_alu
    import fibo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] alu_res_o,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Results wrap modulo 2^WIDTH; non-ALU opcodes produce zero and are ignored upstream.
    always_comb begin
        alu_res_o = '0;
        case (opcode_i)
            OP_SUB:  alu_res_o = a_i - b_i;
            OP_DEC:  alu_res_o = a_i - ONE;
            OP_ADD:  alu_res_o = a_i + b_i;
            OP_PASS: alu_res_o = b_i;
            default: alu_res_o = '0;
        endcase
    end

    assign zero_o = (alu_res_o == '0);

endmodule

// File: rtl/fibo_datapath.sv
// rtl/fibo_datapath.sv - register file, accumulator and result capture for the Fibonacci controller
module fibo_datapath
    import fibo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       opcode,
    input  logic [1:0]       operand1,
    input  logic [1:0]       operand2,
    input  logic             DONE,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             ZERO_FLAG,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_VALID
);

    logic [WIDTH-1:0] rf_q [0:3];
    logic [WIDTH-1:0] rf_d [0:3];
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             z_q, z_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_op;

    // Operands always come from the pre-edge register file (read-before-write).
    assign opa    = rf_q[operand1];
    assign opb    = rf_q[operand2];
    assign alu_op = is_alu_op(opcode);

    fibo_alu #(.WIDTH(WIDTH)) u_alu (
        .opcode_i  (opcode),
        .a_i       (opa),
        .b_i       (opb),
        .alu_res_o (alu_res),
        .zero_o    (alu_zero)
    );

    // Controller branches in the issuing cycle, so ALU ops bypass the Z register.
    assign ZERO_FLAG    = alu_op ? alu_zero : z_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;

    // Next-state decode: register write-back, ACC/Z load and DONE capture.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rf_d[i] = rf_q[i];
        end
        acc_d    = acc_q;
        z_d      = z_q;
        result_d = result_q;
        valid_d  = valid_q;

        case (opcode)
            OP_LDK:  rf_d[operand1] = {{(WIDTH-2){1'b0}}, operand2};
            OP_LDIN: rf_d[operand1] = DATA_IN;
            OP_WB:   rf_d[operand1] = acc_q;
            default: ;
        endcase

        if (alu_op) begin
            acc_d = alu_res;
            z_d   = alu_zero;
        end

        // A new run (LDIN without DONE) invalidates the held result but keeps its value.
        if (DONE) begin
            result_d = rf_q[operand1];
            valid_d  = 1'b1;
        end else if (opcode == OP_LDIN) begin
            valid_d  = 1'b0;
        end
    end

    // State registers with synchronous active-high reset overriding any opcode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            acc_q    <= '0;
            z_q      <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
            acc_q    <= acc_d;
            z_q      <= z_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_fibo_datapath.sv
// tb/tb_fibo_datapath.sv - vector table and Fibonacci program bench for fibo_datapath
module tb_fibo_datapath;
    import fibo_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] opcode;
    logic [1:0] operand1;
    logic [1:0] operand2;
    logic       DONE;
    logic [7:0] DATA_IN;
    logic       ZERO_FLAG;
    logic [7:0] RESULT;
    logic       RESULT_VALID;

    int checks   = 0;
    int failures = 0;

    fibo_datapath #(.WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .opcode       (opcode),
        .operand1     (operand1),
        .operand2     (operand2),
        .DONE         (DONE),
        .DATA_IN      (DATA_IN),
        .ZERO_FLAG    (ZERO_FLAG),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic       done;
        logic [7:0] din;
        logic       chk_z;
        logic       exp_z;
        logic [7:0] exp_res;
        logic       exp_v;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       v;
        int         tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    function automatic vec_t mk(logic rst, logic [2:0] op, logic [1:0] a, logic [1:0] b,
                                logic done, logic [7:0] din, logic chk_z, logic exp_z,
                                logic [7:0] exp_res, logic exp_v);
        vec_t v;
        v.rst = rst; v.op = op; v.a = a; v.b = b; v.done = done; v.din = din;
        v.chk_z = chk_z; v.exp_z = exp_z; v.exp_res = exp_res; v.exp_v = exp_v;
        return v;
    endfunction

    function automatic logic [7:0] fib_ref(int n);
        logic [7:0] x, y, t;
        x = 8'd0;
        y = 8'd1;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(string name, int tag, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
        end
    endtask

    // Drive one instruction, sample ZERO_FLAG mid-cycle, return after the edge.
    task automatic drive(input logic rst, input logic [2:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic done, input logic [7:0] din,
                         output logic zf);
        RST = rst; opcode = op; operand1 = a; operand2 = b; DONE = done; DATA_IN = din;
        @(negedge CLK);
        zf = ZERO_FLAG;
        @(posedge CLK);
        #1;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", -1, 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            check("result", e.tag, RESULT, e.res);
            check("result_valid", e.tag, {7'd0, RESULT_VALID}, {7'd0, e.v});
        end
    endtask

    task automatic apply(vec_t v, int tag);
        logic zf;
        sb_q.push_back('{res: v.exp_res, v: v.exp_v, tag: tag});
        drive(v.rst, v.op, v.a, v.b, v.done, v.din, zf);
        if (v.chk_z) check("zero_flag", tag, {7'd0, zf}, {7'd0, v.exp_z});
        compare_out();
    endtask

    // Behavioural controller running the Fibonacci program on the datapath.
    task automatic run_fib(int n, int tag);
        logic zf;
        bit   found;
        drive(1'b0, OP_LDIN, R2, R0, 1'b0, 8'(n), zf);
        check("fib_valid_clear", tag, {7'd0, RESULT_VALID}, 8'd0);
        drive(1'b0, OP_LDK, R0, 2'd0, 1'b0, 8'd0, zf);
        drive(1'b0, OP_LDK, R1, 2'd1, 1'b0, 8'd0, zf);
        found = 1'b0;
        for (int it = 0; it < 64; it++) begin
            drive(1'b0, OP_PASS, R0, R2, 1'b0, 8'd0, zf);
            if (zf) begin
                found = 1'b1;
                break;
            end
            drive(1'b0, OP_ADD,  R0, R1, 1'b0, 8'd0, zf);
            drive(1'b0, OP_WB,   R3, R0, 1'b0, 8'd0, zf);
            drive(1'b0, OP_PASS, R0, R1, 1'b0, 8'd0, zf);
            drive(1'b0, OP_WB,   R0, R0, 1'b0, 8'd0, zf);
            drive(1'b0, OP_PASS, R0, R3, 1'b0, 8'd0, zf);
            drive(1'b0, OP_WB,   R1, R0, 1'b0, 8'd0, zf);
            drive(1'b0, OP_DEC,  R2, R0, 1'b0, 8'd0, zf);
            drive(1'b0, OP_WB,   R2, R0, 1'b0, 8'd0, zf);
        end
        if (!found) begin
            check("fib_timeout", tag, 8'd1, 8'd0);
        end else begin
            sb_q.push_back('{res: fib_ref(n), v: 1'b1, tag: tag});
            drive(1'b0, OP_NOP, R0, R0, 1'b1, 8'd0, zf);
            compare_out();
        end
        drive(1'b0, OP_NOP, R0, R0, 1'b0, 8'd0, zf);
    endtask

    initial begin
        RST = 1'b1; opcode = OP_NOP; operand1 = R0; operand2 = R0; DONE = 1'b0; DATA_IN = 8'd0;
        @(posedge CLK);
        #1;

        //             rst  op       a   b   done din     chkz z     res     v
        // reset mid-run
        tbl.push_back(mk(1, OP_NOP,  R0, R0, 0, 8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_NOP,  R0, R0, 0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_LDIN, R3, R0, 0, 8'h05, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_PASS, R0, R3, 0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_NOP,  R3, R0, 1, 8'h00, 1, 0, 8'h05, 1));
        tbl.push_back(mk(1, OP_NOP,  R0, R0, 0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_NOP,  R0, R0, 0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_NOP,  R0, R0, 1, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_NOP,  R1, R0, 1, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_NOP,  R2, R0, 1, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_NOP,  R3, R0, 1, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_WB,   R0, R0, 0, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_NOP,  R0, R0, 1, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_LDIN, R2, R0, 0, 8'h00, 1, 0, 8'h00, 0));
        // LDK / PASS / WB
        tbl.push_back(mk(0, OP_LDK,  R1, 2'd3, 0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_PASS, R0, R1, 0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_WB,   R2, R0, 0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, OP_NOP,  R2, R0, 1, 8'h00, 1, 0, 8'h03, 1));
        tbl.push_back(mk(0, OP_PASS, R1, R0, 0, 8'h00, 1, 1, 8'h03, 1));
        tbl.push_back(mk(0, OP_NOP,  R0, R0, 0, 8'h00, 1, 1, 8'h03, 1));
        // wrap-around
        tbl.push_back(mk(0, OP_LDIN, R0, R0, 0, 8'hFF, 1, 1, 8'h03, 0));
        tbl.push_back(mk(0, OP_LDK,  R1, 2'd1, 0, 8'h00, 1, 1, 8'h03, 0));
        tbl.push_back(mk(0, OP_ADD,  R0, R1, 0, 8'h00, 1, 1, 8'h03, 0));
        tbl.push_back(mk(0, OP_WB,   R2, R0, 0, 8'h00, 1, 1, 8'h03, 0));
        tbl.push_back(mk(0, OP_NOP,  R2, R0, 1, 8'h00, 1, 1, 8'h00, 1));
        tbl.push_back(mk(0, OP_LDK,  R3, 2'd0, 0, 8'h00, 1, 1, 8'h00, 1));
        tbl.push_back(mk(0, OP_DEC,  R3, R0, 0, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_WB,   R2, R0, 0, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_NOP,  R2, R0, 1, 8'h00, 1, 0, 8'hFF, 1));
        tbl.push_back(mk(0, OP_SUB,  R1, R1, 0, 8'h00, 1, 1, 8'hFF, 1));
        tbl.push_back(mk(0, OP_SUB,  R1, R0, 0, 8'h00, 1, 0, 8'hFF, 1));
        tbl.push_back(mk(0, OP_WB,   R3, R0, 0, 8'h00, 1, 0, 8'hFF, 1));
        tbl.push_back(mk(0, OP_NOP,  R3, R0, 1, 8'h00, 1, 0, 8'h02, 1));
        // read-before-write
        tbl.push_back(mk(0, OP_LDK,  R3, 2'd1, 0, 8'h00, 1, 0, 8'h02, 1));
        tbl.push_back(mk(0, OP_SUB,  R0, R0, 0, 8'h00, 1, 1, 8'h02, 1));
        tbl.push_back(mk(0, OP_WB,   R3, R3, 1, 8'h00, 1, 1, 8'h01, 1));
        tbl.push_back(mk(0, OP_DEC,  R3, R0, 1, 8'h00, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, OP_WB,   R1, R0, 0, 8'h00, 1, 0, 8'h00, 1));
        // DONE hold then clear on LDIN
        tbl.push_back(mk(0, OP_NOP,  R1, R0, 1, 8'h00, 1, 0, 8'hFF, 1));
        tbl.push_back(mk(0, OP_NOP,  R1, R0, 1, 8'h00, 1, 0, 8'hFF, 1));
        tbl.push_back(mk(0, OP_NOP,  R1, R0, 1, 8'h00, 1, 0, 8'hFF, 1));
        tbl.push_back(mk(0, OP_LDIN, R2, R0, 0, 8'h07, 1, 0, 8'hFF, 0));
        tbl.push_back(mk(0, OP_NOP,  R0, R0, 0, 8'h00, 1, 0, 8'hFF, 0));
        tbl.push_back(mk(0, OP_ADD,  R2, R1, 0, 8'h00, 1, 0, 8'hFF, 0));
        tbl.push_back(mk(0, OP_WB,   R0, R0, 0, 8'h00, 1, 0, 8'hFF, 0));
        tbl.push_back(mk(0, OP_NOP,  R0, R0, 1, 8'h00, 1, 0, 8'h06, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        run_fib(7, 1007);
        run_fib(1, 1001);
        run_fib(10, 1010);

        if (sb_q.size() != 0) check("scoreboard_leftover", -1, 8'(sb_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fibo_datapath.md
Name: fibo_datapath

Overview:
- Execution unit for the Fibonacci controller FSM.
- Each CLK cycle it decodes the controller's {opcode, operand1, operand2} word against a 4-entry register file, an ALU and an accumulator.
- Returns ZERO_FLAG so the controller can branch, and captures the final result when the controller raises DONE.
- Clocked by the controller's forwarded clock (Clk_out drives CLK).

Parameters:
WIDTH, 8, data width of registers R0-R3, ACC, DATA_IN and RESULT

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, synchronous and active-high
opcode  input  3  instruction from controller
operand1  input  2  register index A (destination for writes)
operand2  input  2  register index B, or 2-bit immediate for LDK
DONE  input  1  controller finished; capture result
DATA_IN  input  WIDTH  external value (sequence index N) for LDIN
ZERO_FLAG  output  1  zero status to controller
RESULT  output  WIDTH  captured final value
RESULT_VALID  output  1  high while RESULT holds a captured value

Behaviour:
- Reset (RST=1 at a rising CLK edge) clears R0-R3, ACC, the Z register, RESULT and RESULT_VALID to 0. Reset overrides every opcode, including mid-sequence.
- Opcode map (A = R[operand1], B = R[operand2]):
  - 000 NOP: no state change.
  - 001 LDK: R[operand1] <= zero-extended operand2.
  - 010 SUB: ACC <= A - B.
  - 011 DEC: ACC <= A - 1.
  - 100 LDIN: R[operand1] <= DATA_IN.
  - 101 WB: R[operand1] <= ACC.
  - 110 ADD: ACC <= A + B.
  - 111 PASS: ACC <= B.
- Arithmetic: all ALU results are truncated to WIDTH (mod 2^WIDTH wrap). 0-1 = all ones. 0xFF+0x01 = 0x00 at WIDTH=8. No carry or overflow output.
- ALU ops (010, 011, 110, 111):
  - alu_res is computed combinationally from the current inputs.
  - ACC and the Z register load at the edge ending the cycle; Z <= (alu_res==0).
- ZERO_FLAG is combinational:
  - During an ALU op it equals (alu_res==0) in the same cycle, so a Moore controller can branch on the edge ending the issuing state.
  - In all other cycles it equals the Z register (last ALU outcome).
- Reads and writes to the same register in one cycle: operands read the pre-edge value (read-before-write). WB with operand1==operand2 is legal.
- Latency: register writes and ACC are visible the cycle after issue; ZERO_FLAG for ALU ops has 0 cycles latency.
- DONE handling:
  - On the edge where DONE=1: RESULT <= R[operand1] and RESULT_VALID <= 1. The opcode in the same cycle still executes; its register write and DONE capture use pre-edge values.
  - While DONE stays high, RESULT re-captures every cycle (stable if no writes).
  - RESULT_VALID falls to 0 on the first edge where DONE=0 and opcode is LDIN (new run); RESULT holds its value.
- Undefined/X operands are not required to be handled; the bench never drives X after reset.

Decomposition:
- Package fibo_pkg holds:
  - the opcode localparams: OP_NOP, OP_LDK, OP_SUB, OP_DEC, OP_LDIN, OP_WB, OP_ADD, OP_PASS;
  - the register-index constants R0-R3;
  - an is_alu_op function.
- One sub-module, fibo_alu: purely combinational, taking opcode, A and B and producing alu_res and zero. The top level holds the register file, ACC, Z, the RESULT capture and write-back muxing.

Test Plan:
- Reset mid-run: load R3=5 via LDIN, assert RST for one cycle -> R0-R3, ACC, RESULT and RESULT_VALID read 0; ZERO_FLAG=0 during the following NOP.
- LDK/PASS/WB: LDK R1,#3; PASS R0,R1; WB R2 -> R2=3; ZERO_FLAG=0 during PASS. PASS on R0=0 -> ZERO_FLAG=1 in the same cycle.
- Wrap-around (WIDTH=8): R0=0xFF, R1=0x01; ADD R0,R1 -> ACC=0x00 and ZERO_FLAG=1 in the issue cycle. DEC on R0=0 -> ACC=0xFF, ZERO_FLAG=0.
- Read-before-write: R3=1; WB R3 with ACC=0 in the same cycle as a following DEC read -> the DEC uses the post-WB value only on the next cycle; check ACC=0xFF, not 0x00.
- Full Fibonacci program driven by a behavioural controller with DATA_IN=7 -> DONE asserts with RESULT=13 (F7) and RESULT_VALID=1. DATA_IN=1 -> RESULT=1.
- DONE hold/clear: keep DONE high 3 cycles -> RESULT stable, RESULT_VALID=1. Then DONE=0 with an LDIN issued -> RESULT_VALID=0, RESULT unchanged.
